// File: rtl/gain_ramp_arb.sv
// Two-requester gain ramp arbiter: grants host or sweep round-robin and
// walks Gain_Dout toward the captured target in bounded, timed steps.
module gain_ramp_arb #(
  parameter int WIDTH    = 12,
  parameter int STEP     = 16,
  parameter int TICK_DIV = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req_H,
  input  logic [WIDTH-1:0] Data_H,
  input  logic             Req_S,
  input  logic [WIDTH-1:0] Data_S,
  output logic             Ack_H,
  output logic             Ack_S,
  output logic [WIDTH-1:0] Gain_Dout,
  output logic             Gain_EN,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]    RELOAD = CW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  typedef enum logic {
    IDLE,
    RAMP
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] target, target_n;
  logic [WIDTH-1:0] gain_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             prio_s, prio_n;
  logic             armed;
  logic             ack_h_n, ack_s_n;
  logic             en_n, busy_n, done_n;

  logic             req_h_m, req_s_m;
  logic             grant_h, grant_s;
  logic [WIDTH-1:0] grant_data;

  logic [WIDTH:0]   diff, mag;
  logic             up;
  logic [WIDTH-1:0] step_nxt;

  // A requester still seeing its own Ack is dropping its request.
  always_comb begin
    req_h_m    = Req_H & ~Ack_H & armed;
    req_s_m    = Req_S & ~Ack_S & armed;
    grant_h    = req_h_m & (~req_s_m | ~prio_s);
    grant_s    = req_s_m & ~grant_h;
    grant_data = grant_h ? Data_H : Data_S;
  end

  always_comb begin
    diff = {1'b0, target} - {1'b0, Gain_Dout};
    up   = ~diff[WIDTH];
    mag  = up ? diff : (~diff + 1'b1);
    if (mag <= {1'b0, STEP_N}) begin
      step_nxt = target;
    end else if (up) begin
      step_nxt = Gain_Dout + STEP_N;
    end else begin
      step_nxt = Gain_Dout - STEP_N;
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    gain_n   = Gain_Dout;
    cnt_n    = cnt;
    prio_n   = prio_s;
    ack_h_n  = 1'b0;
    ack_s_n  = 1'b0;
    en_n     = 1'b0;
    busy_n   = Busy;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (grant_h | grant_s) begin
          ack_h_n  = grant_h;
          ack_s_n  = grant_s;
          prio_n   = grant_h;
          target_n = grant_data;
          if (grant_data == Gain_Dout) begin
            done_n = 1'b1;
          end else begin
            state_n = RAMP;
            busy_n  = 1'b1;
            cnt_n   = RELOAD;
          end
        end
      end
      RAMP: begin
        if (cnt == '0) begin
          gain_n = step_nxt;
          en_n   = 1'b1;
          cnt_n  = RELOAD;
          if (step_nxt == target) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      target    <= '0;
      Gain_Dout <= '0;
      cnt       <= '0;
      prio_s    <= 1'b0;
      armed     <= 1'b0;
      Ack_H     <= 1'b0;
      Ack_S     <= 1'b0;
      Gain_EN   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      Gain_Dout <= gain_n;
      cnt       <= cnt_n;
      prio_s    <= prio_n;
      armed     <= 1'b1;
      Ack_H     <= ack_h_n;
      Ack_S     <= ack_s_n;
      Gain_EN   <= en_n;
      Busy      <= busy_n;
      Done      <= done_n;
    end
  end

endmodule

// File: tb/tb_gain_ramp_arb.sv
// Bench for gain_ramp_arb: directed scenarios plus random requests
// checked against an arithmetic ramp/arbitration model.
module tb_gain_ramp_arb;

  localparam int W    = 12;
  localparam int STEP = 16;
  localparam int TD   = 4;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Req_H = 1'b0;
  logic         Req_S = 1'b0;
  logic [W-1:0] Data_H = '0;
  logic [W-1:0] Data_S = '0;
  logic         Ack_H, Ack_S, Gain_EN, Busy, Done;
  logic [W-1:0] Gain_Dout;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int mgain  = 0;
  bit host_next = 1'b1;

  always #5 Clock = ~Clock;

  gain_ramp_arb #(.WIDTH(W), .STEP(STEP), .TICK_DIV(TD)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req_H(Req_H), .Data_H(Data_H),
    .Req_S(Req_S), .Data_S(Data_S),
    .Ack_H(Ack_H), .Ack_S(Ack_S),
    .Gain_Dout(Gain_Dout), .Gain_EN(Gain_EN),
    .Busy(Busy), .Done(Done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int next_gain(input int g, input int t);
    if (t > g) return (t - g <= STEP) ? t : g + STEP;
    return (g - t <= STEP) ? t : g - STEP;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gain"}, Gain_Dout, 0);
    chk({tag, "_en"}, Gain_EN, 0);
    chk({tag, "_ackh"}, Ack_H, 0);
    chk({tag, "_acks"}, Ack_S, 0);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    Req_H = 1'b0;
    Req_S = 1'b0;
    mgain = 0;
    host_next = 1'b1;
    @(negedge Clock);
    check_idle_outputs("rst");
  endtask

  task automatic wait_ack(input bit exp_h, input int exp_lat);
    int lat = 0;
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clock);
      lat++;
      if (Ack_H | Ack_S) got = 1'b1;
    end
    chk("ack_seen", got, 1);
    chk("ack_h", Ack_H, exp_h);
    chk("ack_s", Ack_S, !exp_h);
    if (exp_lat > 0) chk("ack_latency", lat, exp_lat);
    if (exp_h) Req_H = 1'b0;
    else Req_S = 1'b0;
    host_next = !exp_h;
  endtask

  // Called in the Ack cycle; ends at the Done cycle.
  task automatic ramp(input int t);
    int g = mgain;
    if (t == g) begin
      chk("eq_done", Done, 1);
      chk("eq_busy", Busy, 0);
      chk("eq_en", Gain_EN, 0);
      return;
    end
    chk("ramp_busy0", Busy, 1);
    chk("ramp_done0", Done, 0);
    while (g != t) begin
      for (int k = 0; k < TD - 1; k++) begin
        @(negedge Clock);
        chk("tick_en", Gain_EN, 0);
        chk("tick_gain", Gain_Dout, g);
        chk("tick_busy", Busy, 1);
        chk("tick_noack", Ack_H | Ack_S, 0);
      end
      g = next_gain(g, t);
      @(negedge Clock);
      chk("upd_en", Gain_EN, 1);
      chk("upd_gain", Gain_Dout, g);
      chk("upd_done", Done, g == t);
      chk("upd_busy", Busy, g != t);
      chk("upd_noack", Ack_H | Ack_S, 0);
    end
    mgain = t;
  endtask

  function automatic int rand_target();
    int r = $urandom_range(0, 9);
    int v;
    if (r == 0) return mgain;
    if (r == 1) return 0;
    if (r == 2) return (1 << W) - 1;
    v = mgain + $urandom_range(0, 600) - 300;
    if (v < 0) v = 0;
    if (v > (1 << W) - 1) v = (1 << W) - 1;
    return v;
  endfunction

  initial begin
    int th, ts;
    bit w;
    @(negedge Clock);
    check_idle_outputs("in_rst");

    // release, request on the same cycle: grant on the second edge
    Reset  = 1'b0;
    Req_H  = 1'b1;
    Data_H = 12'd40;
    wait_ack(1'b1, 2);
    ramp(40);

    Req_S  = 1'b1;
    Data_S = 12'd8;
    wait_ack(1'b0, 0);
    ramp(8);
    @(negedge Clock);
    chk("after_busy", Busy, 0);

    Req_H  = 1'b1;
    Data_H = 12'd8;
    wait_ack(1'b1, 0);
    ramp(8);
    @(negedge Clock);
    chk("eq_next_en", Gain_EN, 0);
    chk("eq_next_done", Done, 0);
    chk("eq_next_gain", Gain_Dout, 8);

    // simultaneous requests after reset: host first, sweep right after Done
    do_reset();
    Reset  = 1'b0;
    Req_H  = 1'b1;
    Data_H = 12'd100;
    Req_S  = 1'b1;
    Data_S = 12'd200;
    wait_ack(1'b1, 2);
    ramp(100);
    wait_ack(1'b0, 1);
    ramp(200);

    Req_H  = 1'b1;
    Data_H = 12'd4090;
    wait_ack(1'b1, 0);
    ramp(4090);
    Req_S  = 1'b1;
    Data_S = 12'd4095;
    wait_ack(1'b0, 0);
    ramp(4095);

    // reset in the middle of a ramp toward full scale
    do_reset();
    Reset  = 1'b0;
    Req_H  = 1'b1;
    Data_H = 12'd4095;
    wait_ack(1'b1, 2);
    repeat (2 * TD) @(negedge Clock);
    chk("mid_gain", Gain_Dout, 32);
    #2 Reset = 1'b1;
    #1;
    chk("abort_gain", Gain_Dout, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_en", Gain_EN, 0);
    mgain = 0;
    host_next = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 2 * TD; i++) begin
      @(negedge Clock);
      chk("post_en", Gain_EN, 0);
      chk("post_done", Done, 0);
    end
    Req_S  = 1'b1;
    Data_S = 12'd100;
    wait_ack(1'b0, 1);
    ramp(100);

    // random traffic against the model
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge Clock);
      case ($urandom_range(0, 2))
        0: begin
          th = rand_target();
          Req_H = 1'b1;
          Data_H = W'(th);
          wait_ack(1'b1, 0);
          ramp(th);
        end
        1: begin
          ts = rand_target();
          Req_S = 1'b1;
          Data_S = W'(ts);
          wait_ack(1'b0, 0);
          ramp(ts);
        end
        default: begin
          th = rand_target();
          ts = rand_target();
          w  = host_next;
          Req_H = 1'b1;
          Data_H = W'(th);
          Req_S = 1'b1;
          Data_S = W'(ts);
          wait_ack(w, 0);
          ramp(w ? th : ts);
          wait_ack(!w, 1);
          ramp(w ? ts : th);
        end
      endcase
    end
    @(negedge Clock);
    chk("final_busy", Busy, 0);
    chk("final_gain", Gain_Dout, mgain);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gain_ramp_arb.md
GAIN_RAMP_ARB -- requirements
Module: gain_ramp_arb

Interface
REQ-001 Parameter: WIDTH, 12, gain word width.
REQ-002 Parameter: STEP, 16, maximum gain change per update, range 1..2^WIDTH-1.
REQ-003 Parameter: TICK_DIV, 4, clock cycles between successive updates, >=1.
REQ-004 Clock  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Req_H  input  1  host request, level; held until Ack_H.
REQ-007 Data_H  input  WIDTH  host target gain, valid while Req_H=1.
REQ-008 Req_S  input  1  sweep-engine request, level; held until Ack_S.
REQ-009 Data_S  input  WIDTH  sweep target gain, valid while Req_S=1.
REQ-010 Ack_H / Ack_S  output  1 each  one-cycle grant pulse; target captured.
REQ-011 Gain_Dout  output  WIDTH  value presented to the gain register Din.
REQ-012 Gain_EN  output  1  one-cycle load strobe for the gain register EN.
REQ-013 Busy  output  1  high while a ramp is in progress.
REQ-014 Done  output  1  one-cycle pulse when Gain_Dout reaches the target.

Function
REQ-015 The block SHALL implement two states, IDLE and RAMP; all outputs SHALL be registered.
REQ-016 In IDLE with any Req high, the block SHALL grant one requester, latch its Data as target, and pulse its Ack in the next cycle.
REQ-017 If both Req are high in the same IDLE cycle, the block SHALL grant the requester not granted last (round-robin); after reset, host SHALL have priority.
REQ-018 A single pending request SHALL be granted regardless of the round-robin pointer; the pointer SHALL update only on a grant.
REQ-019 If the latched target equals Gain_Dout, the block SHALL pulse Done in the Ack cycle, issue no Gain_EN, and remain in IDLE.
REQ-020 Otherwise the block SHALL enter RAMP, set Busy=1, and load tick counter = TICK_DIV-1 in the Ack cycle.
REQ-021 In RAMP the counter SHALL decrement each cycle; when it is 0, the next edge SHALL update Gain_Dout, pulse Gain_EN, and reload TICK_DIV-1.
REQ-022 Step rule: the block SHALL compute the difference at WIDTH+1 bits unsigned-safe; if |target-Gain_Dout| <= STEP then next = target, else next = Gain_Dout +/- STEP toward target.
REQ-023 Gain_Dout SHALL never wrap past 0 or 2^WIDTH-1.
REQ-024 The update that makes Gain_Dout equal to target SHALL also pulse Done, clear Busy, and return the block to IDLE at the same edge.
REQ-025 Requests arriving during RAMP SHALL NOT be acknowledged; they SHALL be arbitrated in the first IDLE cycle (the Done cycle), with Ack one cycle later.
REQ-026 Gain_Dout SHALL change only on cycles where Gain_EN=1 is asserted.
REQ-027 Ack_H and Ack_S SHALL never be high in the same cycle.

Reset
REQ-028 While Reset=1, the block SHALL hold state IDLE, Gain_Dout=0, Gain_EN=0, Ack_H=0, Ack_S=0, Busy=0, Done=0, counter=0, round-robin pointer = host-first, and target=0.
REQ-029 Reset asserted mid-RAMP SHALL abort the ramp immediately with no further Gain_EN and no Done pulse.
REQ-030 After Reset deasserts, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-031 Reset, then Req_H=1, Data_H=40 -> Ack_H pulse; Gain_EN pulses at 4-cycle spacing with Gain_Dout 16, 32, 40; Done on the third pulse.
REQ-032 From 40, Req_S=1, Data_S=8 -> Ack_S; Gain_Dout 24, 8; Done with the second pulse; Busy low afterward.
REQ-033 After reset, Req_H and Req_S high together (targets 100, 200) -> Ack_H first, ramp to 100; then Ack_S in the cycle after Done; ramp 100 -> 200.
REQ-034 Request with target equal to current Gain_Dout (e.g. 8 at 8) -> Ack and Done in the same cycle; no Gain_EN; Busy stays 0.
REQ-035 Reset pulsed during a ramp 0 -> 4095 after the 2nd update -> Gain_Dout=0 and Busy=0 immediately; no Done; a new request after release ramps from 0.
REQ-036 Target 4095 from 4090 with STEP=16 -> single update to 4095 with no overflow; Done.
